// File: rtl/booth_pkg.sv
// Shared constants and FSM state type for the Booth operand sequencer.
package booth_pkg;

  localparam int unsigned W           = 8;
  localparam int unsigned PW          = 2 * W;
  localparam int unsigned TIMEOUT_DEF = 255;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ARM,
    RUN,
    DRAIN,
    OUT
  } state_t;

endpackage

// File: rtl/booth_op_fifo.sv
// Operand-pair FIFO; entries hold {a, b}, pointers wrap modulo DEPTH.
module booth_op_fifo #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/booth_seq.sv
// Streams buffered operand pairs into the Booth core's start/done handshake
// and holds each product (or an abort marker) until the consumer takes it.
module booth_seq
  import booth_pkg::*;
#(
  parameter int unsigned W       = booth_pkg::W,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = booth_pkg::TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_result,
  output logic             out_timeout,
  output logic             busy,
  output logic [W-1:0]     m_A,
  output logic [W-1:0]     m_B,
  output logic             m_Awrite,
  output logic             m_Bwrite,
  output logic             m_start,
  input  logic             m_done,
  input  logic [2*W-1:0]   m_Result
);

  localparam int unsigned CW  = $clog2(DEPTH) + 1;
  localparam int unsigned WDW = $clog2(TIMEOUT + 1) + 1;

  state_t           state;
  logic [WDW-1:0]   wd;
  logic [WDW-1:0]   wd_next;
  logic [2*W-1:0]   head;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;

  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign pop      = (state == LOAD);
  assign busy     = (state != IDLE) || (count != '0);
  assign wd_next  = wd + WDW'(1);

  booth_op_fifo #(
    .W     (2 * W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({in_a, in_b}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wd          <= '0;
      m_A         <= '0;
      m_B         <= '0;
      m_Awrite    <= 1'b0;
      m_Bwrite    <= 1'b0;
      m_start     <= 1'b0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Operands are registered on entry so they are valid for the whole LOAD cycle.
          if (!empty) begin
            m_A      <= head[2*W-1:W];
            m_B      <= head[W-1:0];
            m_Awrite <= 1'b1;
            m_Bwrite <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          m_Awrite <= 1'b0;
          m_Bwrite <= 1'b0;
          state    <= ARM;
        end
        ARM: begin
          wd      <= '0;
          m_start <= 1'b1;
          state   <= RUN;
        end
        RUN: begin
          wd <= wd_next;
          if (m_done) begin
            out_result  <= m_Result;
            out_timeout <= 1'b0;
            m_start     <= 1'b0;
            state       <= DRAIN;
          end else if (wd_next >= WDW'(TIMEOUT)) begin
            out_result  <= '0;
            out_timeout <= 1'b1;
            m_start     <= 1'b0;
            state       <= DRAIN;
          end
        end
        DRAIN: begin
          if (!m_done) begin
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq.sv
// Scoreboard bench for booth_seq driving a behavioural Booth core model.
module tb_booth_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_timeout;
  logic        busy;
  logic [7:0]  m_A;
  logic [7:0]  m_B;
  logic        m_Awrite;
  logic        m_Bwrite;
  logic        m_start;
  logic        m_done;
  logic [15:0] m_Result;

  int tests = 0;
  int fails = 0;

  logic [16:0] exp_q[$];
  logic [15:0] op_q[$];

  always #5 clk = ~clk;

  booth_seq #(.W(8), .DEPTH(4), .TIMEOUT(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_timeout(out_timeout), .busy(busy),
    .m_A(m_A), .m_B(m_B), .m_Awrite(m_Awrite), .m_Bwrite(m_Bwrite),
    .m_start(m_start), .m_done(m_done), .m_Result(m_Result)
  );

  // Core model: done rises once start has been seen core_delay times (0 = never).
  int         core_delay;
  int         core_cnt;
  logic [7:0] ca;
  logic [7:0] cb;
  assign m_Result = {{8{ca[7]}}, ca} * {{8{cb[7]}}, cb};

  always @(posedge clk) begin
    if (m_Awrite) ca <= m_A;
    if (m_Bwrite) cb <= m_B;
    if (m_start) begin
      core_cnt <= core_cnt + 1;
      if (core_delay != 0 && core_cnt + 1 >= core_delay) m_done <= 1'b1;
    end else begin
      core_cnt <= 0;
      m_done   <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic prev_aw = 1'b0;
  always @(negedge clk) begin
    if (!rst && m_Awrite) begin
      check("awrite_width", 32'(prev_aw), 0);
      check("bwrite_with_awrite", 32'(m_Bwrite), 1);
      if (op_q.size() == 0) check("load_unexpected", 1, 0);
      else check("load_operands", {m_A, m_B}, op_q.pop_front());
    end
    prev_aw = rst ? 1'b0 : m_Awrite;
  end

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("product_unexpected", {out_timeout, out_result}, 0);
      else check("product", {out_timeout, out_result}, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] res, input logic tmo);
    int n = 0;
    while (!in_ready && n < 200) begin tick(); n++; end
    if (!in_ready) check("push_wait", 0, 1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    op_q.push_back({a, b});
    exp_q.push_back({tmo, res});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || busy || out_valid) && n < 500) begin tick(); n++; end
    check("drain_done", 32'(n < 500), 1);
  endtask

  task automatic measure_start(input string name, input int exp_n);
    int n = 0;
    int w = 0;
    while (!m_start && w < 50) begin tick(); w++; end
    while (m_start && n < 100) begin tick(); n++; end
    check(name, n, exp_n);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [15:0] held;
    logic        bad;
    int          w;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    core_delay = 3; core_cnt = 0; m_done = 1'b0; ca = '0; cb = '0;
    repeat (3) tick();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_m_start", 32'(m_start), 0);
    check("rst_strobes", {m_Awrite, m_Bwrite}, 0);
    check("rst_outputs", {out_timeout, out_result, m_A, m_B}, 0);
    rst = 1'b0;
    tick();

    // Single operation with latency checks
    push(8'hFD, 8'hE1, 16'h005D, 1'b0);
    check("lat_push_edge", 32'(m_Awrite), 0);
    tick();
    check("lat_load", 32'(m_Awrite), 1);
    tick();
    check("arm_strobes", {m_Awrite, m_start}, 0);
    tick();
    check("run_start", 32'(m_start), 1);
    wait_idle();

    // Burst of five with a slow core
    core_delay = 8;
    push(8'hFB, 8'hF8, 16'h0028, 1'b0);
    push(8'h7F, 8'h80, 16'hC080, 1'b0);
    push(8'h80, 8'h80, 16'h4000, 1'b0);
    push(8'h00, 8'h07, 16'h0000, 1'b0);
    push(8'h01, 8'hFF, 16'hFFFF, 1'b0);
    check("burst_full", 32'(in_ready), 0);
    wait_idle();

    // Output back-pressure
    core_delay = 2;
    out_ready = 1'b0;
    push(8'h05, 8'h03, 16'h000F, 1'b0);
    w = 0;
    while (!out_valid && w < 100) begin tick(); w++; end
    check("bp_valid", 32'(out_valid), 1);
    push(8'hFE, 8'h04, 16'hFFF8, 1'b0);
    held = out_result;
    check("bp_held_value", 32'(held), 32'h000F);
    bad = 1'b0;
    repeat (20) begin
      tick();
      if (!out_valid || out_result !== held || m_Awrite) bad = 1'b1;
    end
    check("bp_stable_no_load", 32'(bad), 0);
    check("bp_busy", 32'(busy), 1);
    out_ready = 1'b1;
    wait_idle();

    // Core never completes
    core_delay = 0;
    push(8'h03, 8'h03, 16'h0000, 1'b1);
    measure_start("timeout_run_cycles", 10);
    wait_idle();

    // Done arrives on the final watchdog cycle
    core_delay = 9;
    push(8'h02, 8'h03, 16'h0006, 1'b0);
    measure_start("done_at_limit_cycles", 10);
    wait_idle();

    // Reset while running with two pairs queued
    core_delay = 0;
    push(8'h11, 8'h22, 16'h0000, 1'b1);
    push(8'h33, 8'h44, 16'h0000, 1'b1);
    push(8'h55, 8'h66, 16'h0000, 1'b1);
    w = 0;
    while (!m_start && w < 50) begin tick(); w++; end
    check("rr_running", 32'(m_start), 1);
    op_q.delete();
    exp_q.delete();
    rst = 1'b1;
    tick();
    check("rr_m_start", 32'(m_start), 0);
    check("rr_busy", 32'(busy), 0);
    check("rr_in_ready", 32'(in_ready), 1);
    rst = 1'b0;
    bad = 1'b0;
    repeat (30) begin
      tick();
      if (out_valid || m_Awrite || busy) bad = 1'b1;
    end
    check("rr_quiet_after", 32'(bad), 0);

    check("queues_drained", exp_q.size() + op_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/booth_seq.md
# booth_seq

Operand sequencer that sits directly upstream of the Booth multiplier core (`booth_top`) and also collects its product. It accepts signed operand pairs over a valid/ready stream and buffers them in a small FIFO. For each pair it drives the core's load strobes and `start`, waits for `done`, then captures `Result` into a held output register. It turns the core's level-start/done protocol into a back-pressured stream for the software-facing side of the codesign.

## Interface
Parameters:
- `W`, 8: operand width; the product is `2*W`.
- `DEPTH`, 4: operand FIFO depth, a power of two and at least 2.
- `TIMEOUT`, 255: maximum cycles allowed in RUN before the operation is aborted.

Ports:
- `clk` in 1: the single clock; all logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operand pair offered.
- `in_ready` out 1: FIFO can accept.
- `in_a`, `in_b` in W: signed operands (A, B).
- `out_valid` out 1: product held.
- `out_ready` in 1: consumer takes the product.
- `out_result` out 2W: signed product.
- `out_timeout` out 1: qualifies `out_valid`; this product was aborted.
- `busy` out 1: FSM not in IDLE, or FIFO not empty.
- `m_A`, `m_B` out W: to core `A`/`B`.
- `m_Awrite`, `m_Bwrite` out 1: to core `Awrite`/`Bwrite`.
- `m_start` out 1: to core `start`.
- `m_done` in 1: from core `done`.
- `m_Result` in 2W: from core `Result`.

## Operation
- Core contract:
  - The core latches A/B while its write strobe is high.
  - `start` is held high until `done` is 1.
  - `done` falls after `start` drops.
- Push rule: a push occurs when `in_valid && in_ready`. `in_ready = (count != DEPTH)`, computed from the registered count only. When the FIFO is full, `in_ready` stays 0 even in a cycle that pops.
- IDLE: if the FIFO is non-empty, go to LOAD.
- LOAD (1 cycle):
  - `m_A`/`m_B` = FIFO head; `m_Awrite` = `m_Bwrite` = 1; pop.
  - `m_A`/`m_B` are registered and hold their value until the next LOAD.
- ARM (1 cycle): strobes return to 0; the watchdog is cleared. Next state is RUN.
- RUN:
  - `m_start` = 1; the watchdog increments each cycle.
  - If `m_done` = 1: capture `m_Result` into `out_result`, clear `out_timeout`, go to DRAIN.
  - Else if the watchdog reaches `TIMEOUT`: set `out_result` = 0 and `out_timeout` = 1, go to DRAIN.
  - `m_done` takes priority over the timeout in the same cycle.
- DRAIN: `m_start` = 0. Wait for `m_done` = 0, then go to OUT.
- OUT: `out_valid` = 1. When `out_ready` = 1, go to IDLE.
  - The product is held stable while `out_ready` = 0.
  - No new operation starts while in OUT.
- Pushes are accepted in every state. The FIFO is fully decoupled from the FSM.
- Arithmetic: the block does no arithmetic on operands or products. Both pass through bit-exact as two's complement.

## Timing
- Reset values:
  - All outputs are 0, except `in_ready` = 1 (FIFO empty).
  - FIFO pointers and count are 0; FSM is in IDLE; watchdog is 0.
- Reset mid-operation: `m_start` and the strobes drop on the next edge, the FIFO is flushed, and any pending product is discarded. The core is left to finish on its own.
- Latency, push to `m_Awrite` high: 2 cycles (the push edge, then IDLE→LOAD).
- `m_start` rises 2 cycles after LOAD.
- `out_valid` rises no earlier than 2 cycles after `m_done` is first sampled high (DRAIN, then OUT).
- Back-to-back operations: OUT→IDLE→LOAD adds 2 cycles of overhead between operations.
- FIFO ordering is strict FIFO. Pointers wrap modulo `DEPTH`.

## Structure
- Package `booth_pkg` holds:
  - `W` and the derived product width.
  - The FSM state enum: IDLE, LOAD, ARM, RUN, DRAIN, OUT.
  - The default `TIMEOUT` constant.
- Sub-module `booth_op_fifo`:
  - 2W-bit entries holding the {a, b} pair, `DEPTH` deep.
  - Push/pop/full/empty/count.
  - Synchronous `rst`.
- Top-level `booth_seq` contains the FSM, watchdog counter, operand and result registers, and the FIFO instance.

## Test plan
- Single operation: push A=−3 (8'hFD), B=−31 (8'hE1) against a model core → `m_Awrite` high for exactly 1 cycle with `m_A`=8'hFD, `m_B`=8'hE1; then `out_result` = 16'h005D, `out_timeout` = 0.
- Burst of 5 pushes with `DEPTH`=4 and the core stalled:
  - `in_ready` drops after the 4th buffered pair (the 1st pair has already been popped into LOAD).
  - Products emerge in order: (−5×−8)=16'h0028, (127×−128)=16'hC080, (−128×−128)=16'h4000, (0×7)=16'h0000, (1×−1)=16'hFFFF.
- Output back-pressure: hold `out_ready`=0 for 20 cycles → `out_valid` and `out_result` stay stable; no LOAD occurs; the FIFO still accepts pushes.
- Timeout: the core never asserts done, with `TIMEOUT`=10 → `m_start` drops after 10 RUN cycles; `out_valid`=1, `out_timeout`=1, `out_result`=0.
- Reset mid-RUN with 2 pairs queued → next cycle `m_start`=0, `busy`=0, `in_ready`=1; no product appears afterwards.
- Done and timeout in the same cycle → the captured product is used and `out_timeout`=0.
